// File: rtl/aui_pkg.sv
// aui_pkg: shared lane geometry, per-lane alignment-marker patterns and AM lock FSM state type
package aui_pkg;

    localparam int unsigned AUI_LANE_WIDTH = 1360;
    localparam int unsigned AUI_AM_BITS    = 120;

    // Default AM value per lane; each lane_am_lock instance picks its own entry.
    localparam logic [AUI_AM_BITS-1:0] AM_TABLE [16] = '{
        120'h9A4A26_B665B5_D965B5_D99A4A_2649B6,
        120'h7C7E4F_B65F2A_83813B_0D8A4C_1E0C5D,
        120'h3B8C91_D24A7E_C4736E_2DB5B8_6E3F14,
        120'h5C9E36_A1F0B7_3A61C9_8B24E5_D73A0F,
        120'hE17A2C_490D6B_1E85D3_B6F27A_0C94E8,
        120'h2DF5B1_7C0A93_D20A4E_83F56C_B17E29,
        120'hA83C4D_15E97F_57C3B2_EA1680_4F2D9C,
        120'h4E60B9_C3D271_B19F46_3C2D8E_A0B675,
        120'h1F8A57_E6B3C0_E075A8_194C3F_72D1E4,
        120'hC6329E_0F7DA4_39CD61_F082B5_9E45C3,
        120'h6B4DF0_83A52E_94B20F_7C5AD1_25E8B7,
        120'hD0E718_5A2B9C_2F184E_A5D7E3_C963F0,
        120'h8275C3_F91E46_7DA83B_C2E164_1B0F8D,
        120'hF3916A_2C84D7_C25E07_6E9A3B_83D4C2,
        120'h395BE2_D68F01_A81C74_17F5C9_E24A6B,
        120'hB7C84D_4E13A8_6F39D2_D8B61E_5A71F3
    };

    typedef enum logic [1:0] {AM_SEARCH, AM_VERIFY, AM_LOCKED} am_lock_state_t;

endpackage

// File: rtl/lane_am_lock.sv
// lane_am_lock: finds the per-lane alignment marker, qualifies lock with good/miss hysteresis, forwards words one cycle later
module lane_am_lock
    import aui_pkg::*;
#(
    parameter int unsigned        LANE_WIDTH = AUI_LANE_WIDTH,
    parameter int unsigned        AM_BITS    = AUI_AM_BITS,
    parameter logic [AM_BITS-1:0] AM_PATTERN = AM_TABLE[0],
    parameter int unsigned        AM_PERIOD  = 1024,
    parameter int unsigned        LOCK_GOOD  = 2,
    parameter int unsigned        MISS_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [LANE_WIDTH-1:0] i_lane,
    output logic                  o_valid,
    output logic [LANE_WIDTH-1:0] o_lane,
    output logic                  o_lock,
    output logic                  o_am_slot,
    output logic                  o_am_err,
    output logic [1:0]            o_state
);

    localparam int CW = $clog2(AM_PERIOD);
    localparam int GW = $clog2(LOCK_GOOD + 1);
    localparam int MW = $clog2(MISS_LIMIT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(AM_PERIOD - 1);
    localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_GOOD);
    localparam logic [MW-1:0] MISS_MAX = MW'(MISS_LIMIT);

    am_lock_state_t        state_q, state_d;
    logic [CW-1:0]         word_cnt_q, word_cnt_d;
    logic [GW-1:0]         good_cnt_q, good_cnt_d;
    logic [MW-1:0]         miss_cnt_q, miss_cnt_d;
    logic                  valid_q, slot_q, slot_d, err_q, err_d;
    logic [LANE_WIDTH-1:0] lane_q;

    wire                   match    = i_lane[LANE_WIDTH-1 -: AM_BITS] == AM_PATTERN;
    wire                   at_slot  = word_cnt_q == '0;
    wire  [CW-1:0]         cnt_inc  = word_cnt_q == CNT_LAST ? '0 : word_cnt_q + CW'(1);
    wire  [GW-1:0]         good_inc = good_cnt_q + GW'(1);
    wire  [MW-1:0]         miss_inc = miss_cnt_q + MW'(1);

    // Next state: only valid words advance the FSM and the slot counter; flags describe the current word.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        good_cnt_d = good_cnt_q;
        miss_cnt_d = miss_cnt_q;
        slot_d     = 1'b0;
        err_d      = 1'b0;
        if (i_valid) begin
            case (state_q)
                AM_SEARCH: if (match) begin
                    word_cnt_d = CW'(1);
                    good_cnt_d = GW'(1);
                    miss_cnt_d = '0;
                    state_d    = LOCK_GOOD == 1 ? AM_LOCKED : AM_VERIFY;
                end
                AM_VERIFY: begin
                    word_cnt_d = cnt_inc;
                    if (at_slot && match) begin
                        good_cnt_d = good_inc;
                        if (good_inc == GOOD_MAX) begin
                            state_d    = AM_LOCKED;
                            miss_cnt_d = '0;
                        end
                    end else if (at_slot) begin
                        state_d    = AM_SEARCH;
                        good_cnt_d = '0;
                    end
                end
                AM_LOCKED: begin
                    word_cnt_d = cnt_inc;
                    slot_d     = at_slot;
                    if (at_slot && match) begin
                        miss_cnt_d = '0;
                    end else if (at_slot) begin
                        err_d      = 1'b1;
                        miss_cnt_d = miss_inc;
                        if (miss_inc == MISS_MAX) begin
                            state_d    = AM_SEARCH;
                            good_cnt_d = '0;
                            miss_cnt_d = '0;
                        end
                    end
                end
                default: state_d = AM_SEARCH;
            endcase
        end
    end

    // State and output registers; reset clears any partial lock immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= AM_SEARCH;
            word_cnt_q <= '0;
            good_cnt_q <= '0;
            miss_cnt_q <= '0;
            valid_q    <= 1'b0;
            lane_q     <= '0;
            slot_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            good_cnt_q <= good_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            valid_q    <= i_valid;
            lane_q     <= i_lane;
            slot_q     <= slot_d;
            err_q      <= err_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_lane    = lane_q;
    assign o_lock    = state_q == AM_LOCKED;
    assign o_am_slot = slot_q;
    assign o_am_err  = err_q;
    assign o_state   = state_q;

endmodule

// File: tb/tb_lane_am_lock.sv
// tb_lane_am_lock: directed AM lock scenarios with a queue scoreboard checked by an independent monitor
module tb_lane_am_lock;
    import aui_pkg::*;

    localparam int LW = AUI_LANE_WIDTH;
    localparam int AW = AUI_AM_BITS;
    localparam logic [AW-1:0] P = AM_TABLE[3];

    typedef struct packed {
        logic [LW-1:0] lane;
        logic          lock;
        logic          slot;
        logic          err;
        logic [1:0]    st;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid = 1'b0;
    logic [LW-1:0] i_lane = '0;
    logic          o_valid, o_lock, o_am_slot, o_am_err;
    logic [LW-1:0] o_lane;
    logic [1:0]    o_state;
    exp_t          q[$];
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    lane_am_lock #(
        .LANE_WIDTH(LW), .AM_BITS(AW), .AM_PATTERN(P),
        .AM_PERIOD(8), .LOCK_GOOD(2), .MISS_LIMIT(3)
    ) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_lane(i_lane),
        .o_valid(o_valid), .o_lane(o_lane), .o_lock(o_lock),
        .o_am_slot(o_am_slot), .o_am_err(o_am_err), .o_state(o_state)
    );

    // kind 0: no AM, 1: correct AM, 2: AM with one bit flipped
    function automatic logic [LW-1:0] mk(input int kind, input int tag);
        logic [LW-1:0] v;
        v = '0;
        v[LW-1 -: AW] = kind == 1 ? P : kind == 2 ? (P ^ AW'(1)) : ~P;
        v[31:0] = 32'(tag);
        v[LW-AW-1 -: 32] = ~32'(tag);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_lane(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got am=%h tag=%h expected am=%h tag=%h", name,
                     act[LW-1 -: AW], act[31:0], exp[LW-1 -: AW], exp[31:0]);
        end
    endtask

    task automatic send(input int kind, input int tag, input bit lock, input bit slot, input bit err, input int st);
        exp_t e;
        @(posedge clk);
        #1;
        i_valid = 1'b1;
        i_lane  = mk(kind, tag);
        e.lane = i_lane;
        e.lock = lock;
        e.slot = slot;
        e.err  = err;
        e.st   = 2'(st);
        q.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_lane  = mk(0, 32'hDEAD);
    endtask

    task automatic drain();
        idle();
        repeat (2) @(negedge clk);
        chk("drain_pending", q.size(), 0);
        q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        i_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, int'(o_valid), 0);
        chk({tag, "_lock"}, int'(o_lock), 0);
        chk({tag, "_slot"}, int'(o_am_slot), 0);
        chk({tag, "_err"}, int'(o_am_err), 0);
        chk({tag, "_state"}, int'(o_state), 0);
        chk_lane({tag, "_lane"}, o_lane, '0);
    endtask

    // Monitor: every forwarded word is compared against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_valid === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word got tag=%h expected none", o_lane[31:0]);
                end else begin
                    e = q.pop_front();
                    chk_lane("lane", o_lane, e.lane);
                    chk("lock", int'(o_lock), int'(e.lock));
                    chk("am_slot", int'(o_am_slot), int'(e.slot));
                    chk("am_err", int'(o_am_err), int'(e.err));
                    chk("state", int'(o_state), int'(e.st));
                end
            end else if (rst) begin
                chk("idle_slot", int'(o_am_slot), 0);
                chk("idle_err", int'(o_am_err), 0);
            end
        end
    end

    initial begin
        int k;
        #1 rst = 1'b0;
        #1 chk_zero("reset");
        @(posedge clk);
        #1 rst = 1'b1;

        // Lock at word 13, two corrupted slots recovered by a good one, then three misses drop lock at 69.
        for (int w = 0; w <= 72; w++) begin
            k = (w == 5 || w == 13 || w == 21 || w == 45) ? 1 :
                (w == 29 || w == 37 || w == 53 || w == 61 || w == 69) ? 2 : 0;
            send(k, w, w >= 13 && w < 69,
                 w >= 21 && w <= 69 && (w - 21) % 8 == 0,
                 w == 29 || w == 37 || w == 53 || w == 61 || w == 69,
                 w < 5 ? 0 : w < 13 ? 1 : w < 69 ? 2 : 0);
        end
        drain();

        // Missing AM at the verify slot, an off-slot AM ignored, then relock at 16/24.
        do_reset();
        for (int w = 0; w <= 26; w++) begin
            k = (w == 5 || w == 9 || w == 16 || w == 24) ? 1 : 0;
            send(k, 1000 + w, w >= 24, 1'b0, 1'b0,
                 w < 5 ? 0 : w < 13 ? 1 : w < 16 ? 0 : w < 24 ? 1 : 2);
        end
        drain();

        // Gaps of three idle cycles must not move the slot position.
        do_reset();
        for (int w = 0; w <= 21; w++) begin
            if (w == 3 || w == 10 || w == 13) repeat (3) idle();
            send((w == 5 || w == 13 || w == 21) ? 1 : 0, 2000 + w, w >= 13, w == 21, 1'b0,
                 w < 5 ? 0 : w < 13 ? 1 : 2);
        end
        drain();

        // Asynchronous reset while locked, then a fresh lock at an arbitrary offset.
        do_reset();
        for (int w = 0; w <= 16; w++)
            send((w == 5 || w == 13) ? 1 : 0, 3000 + w, w >= 13, 1'b0, 1'b0,
                 w < 5 ? 0 : w < 13 ? 1 : 2);
        idle();
        chk("pre_reset_lock", int'(o_lock), 1);
        repeat (2) @(negedge clk);
        q.delete();
        #2 rst = 1'b0;
        #1 chk_zero("async_reset");
        @(posedge clk);
        #1 rst = 1'b1;
        for (int w = 0; w <= 11; w++)
            send((w == 2 || w == 10) ? 1 : 0, 4000 + w, w >= 10, 1'b0, 1'b0,
                 w < 2 ? 0 : w < 10 ? 1 : 2);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
